// File: rtl/multi_spinner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_spinner_pkg                                                    |
// | Shared mode/direction types for the multi-channel spinner.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package multi_spinner_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_CLAMP    = 2'b01,
    MODE_ANALOG   = 2'b10,
    MODE_RECENTRE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  // Opposing buttons cancel out, so only a single pressed side is a request.
  function automatic dir_e f_dir_request(input logic left, input logic right);
    if (right && !left) return DIR_RIGHT;
    if (left && !right) return DIR_LEFT;
    return DIR_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spinner_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spinner_channel                                                      |
// | One spinner channel: direction/step FSM plus the value register.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spinner_channel
  import multi_spinner_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STEP_MAX   = 8,
  parameter int STEP_FIXED = 1,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = (1 << WIDTH) - 1,
  parameter int CENTER     = 1 << (WIDTH - 1)
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_left,
  input  logic             i_right,
  input  logic             i_acc,
  input  logic             i_enable,
  input  logic [1:0]       i_mode,
  input  logic [7:0]       i_analog,
  output logic [WIDTH-1:0] o_value
);

  localparam int c_SW = WIDTH + 2;
  // Analog path needs room for the 8-bit stick even on narrow channels.
  localparam int c_AW = (c_SW > 10) ? c_SW : 10;

  localparam logic signed [c_AW-1:0] c_MIN_S    = c_AW'(MIN_VAL);
  localparam logic signed [c_AW-1:0] c_MAX_S    = c_AW'(MAX_VAL);
  localparam logic signed [c_AW-1:0] c_CENTER_S = c_AW'(CENTER);
  localparam logic signed [c_AW-1:0] c_ONE_S    = c_AW'(1);
  localparam logic [WIDTH-1:0]       c_CENTER_V = WIDTH'(CENTER);
  localparam logic [WIDTH-1:0]       c_STEP_MAX = WIDTH'(STEP_MAX);
  localparam logic [WIDTH-1:0]       c_STEP_FIX = WIDTH'(STEP_FIXED);
  localparam logic [WIDTH-1:0]       c_ONE      = WIDTH'(1);

  dir_e                    r_dir;
  dir_e                    w_dir_nxt;
  dir_e                    w_dir_req;
  mode_e                   w_mode;
  logic [WIDTH-1:0]        r_step;
  logic [WIDTH-1:0]        w_step_nxt;
  logic [WIDTH-1:0]        w_step_use;
  logic [WIDTH-1:0]        r_value;
  logic [WIDTH-1:0]        w_value_nxt;
  logic signed [c_SW-1:0]  w_delta;
  logic signed [c_SW-1:0]  w_sum;
  logic signed [c_AW-1:0]  w_sum_ext;
  logic signed [c_AW-1:0]  w_cur;
  logic signed [c_AW-1:0]  w_recentre;
  logic signed [c_AW-1:0]  w_analog_tgt;
  logic signed [7:0]       w_analog_half;

  function automatic logic [WIDTH-1:0] f_clamp(input logic signed [c_AW-1:0] v);
    if (v < c_MIN_S) return c_MIN_S[WIDTH-1:0];
    if (v > c_MAX_S) return c_MAX_S[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_dir   <= DIR_NONE;
      r_step  <= c_ONE;
      r_value <= c_CENTER_V;
    end else if (i_tick) begin
      r_dir   <= w_dir_nxt;
      r_step  <= w_step_nxt;
      r_value <= w_value_nxt;
    end
  end

  always_comb begin
    w_mode     = mode_e'(i_mode);
    w_dir_req  = f_dir_request(i_left, i_right);
    w_dir_nxt  = r_dir;
    w_step_nxt = r_step;
    w_step_use = '0;
    w_delta    = '0;

    if (!i_enable) begin
      w_dir_nxt = DIR_NONE;
    end else if (w_dir_req == DIR_NONE) begin
      w_dir_nxt  = DIR_NONE;
      w_step_nxt = c_ONE;
    end else begin
      if (!i_acc)                    w_step_use = c_STEP_FIX;
      else if (w_dir_req != r_dir)   w_step_use = c_ONE;
      else if (r_step >= c_STEP_MAX) w_step_use = c_STEP_MAX;
      else                           w_step_use = r_step + c_ONE;
      w_step_nxt = w_step_use;
      w_dir_nxt  = w_dir_req;
      w_delta    = (w_dir_req == DIR_RIGHT) ? $signed({2'b00, w_step_use})
                                            : -$signed({2'b00, w_step_use});
    end
  end

  always_comb begin
    w_sum         = $signed({2'b00, r_value}) + w_delta;
    w_sum_ext     = c_AW'(w_sum);
    w_cur         = {{(c_AW - WIDTH){1'b0}}, r_value};
    w_analog_half = $signed(i_analog) >>> 1;
    w_analog_tgt  = c_CENTER_S + c_AW'(w_analog_half);

    if (w_cur < c_CENTER_S)      w_recentre = w_cur + c_ONE_S;
    else if (w_cur > c_CENTER_S) w_recentre = w_cur - c_ONE_S;
    else                         w_recentre = w_cur;

    w_value_nxt = r_value;
    if (i_enable) begin
      case (w_mode)
        MODE_WRAP:     w_value_nxt = w_sum[WIDTH-1:0];
        MODE_CLAMP:    w_value_nxt = f_clamp(w_sum_ext);
        MODE_ANALOG:   w_value_nxt = (i_analog != 8'd0) ? f_clamp(w_analog_tgt)
                                                        : f_clamp(w_sum_ext);
        MODE_RECENTRE: w_value_nxt = (w_delta != '0) ? f_clamp(w_sum_ext)
                                                     : f_clamp(w_recentre);
        default:       w_value_nxt = r_value;
      endcase
    end
  end

  assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/multi_spinner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_spinner                                                        |
// | Frame-strobed multi-channel spinner/paddle position generator.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module multi_spinner
  import multi_spinner_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int STEP_MAX   = 8,
  parameter int STEP_FIXED = 1,
  parameter int MIN_VAL    = 0,
  parameter int MAX_VAL    = (1 << WIDTH) - 1,
  parameter int CENTER     = 1 << (WIDTH - 1)
) (
  input  logic                      clock_40,
  input  logic                      reset_n,
  input  logic                      ctc_zc_to_2,
  input  logic [CHANNELS-1:0]       btn_left,
  input  logic [CHANNELS-1:0]       btn_right,
  input  logic [CHANNELS-1:0]       btn_acc,
  input  logic [CHANNELS-1:0]       use_spinner,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [8*CHANNELS-1:0]     analog,
  output logic [WIDTH*CHANNELS-1:0] spin_angle,
  output logic                      update
);

  // Edges reaching the detector before this many post-reset clocks are ignored.
  localparam logic [2:0] c_GUARD = 3'd4;

  logic [1:0] r_sync;
  logic       r_prev;
  logic [2:0] r_guard;
  logic       r_tick;
  logic       r_update;

  always_ff @(posedge clock_40 or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= 2'b00;
      r_prev   <= 1'b0;
      r_guard  <= 3'd0;
      r_tick   <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], ctc_zc_to_2};
      r_prev   <= r_sync[1];
      if (r_guard != c_GUARD) r_guard <= r_guard + 3'd1;
      r_tick   <= r_sync[1] & ~r_prev & (r_guard == c_GUARD);
      r_update <= r_tick;
    end
  end

  assign update = r_update;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
    spinner_channel #(
      .WIDTH      (WIDTH),
      .STEP_MAX   (STEP_MAX),
      .STEP_FIXED (STEP_FIXED),
      .MIN_VAL    (MIN_VAL),
      .MAX_VAL    (MAX_VAL),
      .CENTER     (CENTER)
    ) u_channel (
      .clk_sys  (clock_40),
      .rst_n    (reset_n),
      .i_tick   (r_tick),
      .i_left   (btn_left[g]),
      .i_right  (btn_right[g]),
      .i_acc    (btn_acc[g]),
      .i_enable (use_spinner[g]),
      .i_mode   (mode[2*g +: 2]),
      .i_analog (analog[8*g +: 8]),
      .o_value  (spin_angle[WIDTH*g +: WIDTH])
    );
  end

endmodule
`default_nettype wire

// File: doc/multi_spinner.md
MULTI_SPINNER -- requirements
Module: multi_spinner

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent spinner/paddle channels (1..8).
REQ-002 SHALL have parameter WIDTH, default 8: bits per channel value.
REQ-003 SHALL have parameter STEP_MAX, default 8: acceleration step ceiling (1..2^(WIDTH-1)-1).
REQ-004 SHALL have parameter STEP_FIXED, default 1: step size when acceleration is off.
REQ-005 SHALL have parameters MIN_VAL, default 0; MAX_VAL, default 2^WIDTH-1; CENTER, default 2^(WIDTH-1): the clamp bounds and recentre target.
REQ-006 SHALL have port clock_40, input, 1: system clock.
REQ-007 SHALL have port reset_n, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port ctc_zc_to_2, input, 1: frame strobe (vsync), asynchronous to logic.
REQ-009 SHALL have port btn_left, input, CHANNELS: decrement request per channel.
REQ-010 SHALL have port btn_right, input, CHANNELS: increment request per channel.
REQ-011 SHALL have port btn_acc, input, CHANNELS: acceleration enable per channel.
REQ-012 SHALL have port use_spinner, input, CHANNELS: channel enable; 0 freezes the value.
REQ-013 SHALL have port mode, input, 2*CHANNELS: per-channel mode, 00 WRAP, 01 CLAMP, 10 ANALOG, 11 RECENTRE.
REQ-014 SHALL have port analog, input, 8*CHANNELS: signed analog stick per channel.
REQ-015 SHALL have port spin_angle, output, WIDTH*CHANNELS: channel values, channel 0 in the LSBs.
REQ-016 SHALL have port update, output, 1: one-cycle pulse when spin_angle has just been updated.

Function
REQ-017 SHALL synchronise ctc_zc_to_2 with 2 flops; its rising edge SHALL produce a single-cycle tick 3 clocks after the input edge.
REQ-018 SHALL update all channels only on tick; spin_angle SHALL change on the clock after tick, with update high for that same cycle.
REQ-019 Direction: right-only gives +step, left-only gives -step; both or neither gives delta 0 and resets step to 1.
REQ-020 Acceleration (btn_acc=1): step SHALL be 1 on the first tick of a press, +1 per consecutive tick in the same direction, saturating at STEP_MAX; a reversal SHALL reload step to 1.
REQ-021 When btn_acc=0, step SHALL equal STEP_FIXED.
REQ-022 WRAP: value SHALL be (value+delta) mod 2^WIDTH.
REQ-023 CLAMP: value SHALL be saturated to [MIN_VAL, MAX_VAL]; arithmetic uses WIDTH+2-bit signed intermediates.
REQ-024 ANALOG: if analog != 0, value SHALL be CENTER + (analog arithmetic-shifted right by 1), clamped; if analog == 0, CLAMP behaviour applies.
REQ-025 RECENTRE: CLAMP with delta != 0; with delta 0, value SHALL move 1 toward CENTER per tick and hold at CENTER.
REQ-026 Mode and enable changes SHALL take effect at the next tick; an out-of-range value on entry to CLAMP, ANALOG or RECENTRE SHALL be clamped at that tick.
REQ-027 use_spinner=0 SHALL hold the value and step, and reset the direction history.

Reset
REQ-028 On reset_n low, all values SHALL be CENTER, step 1, direction none, update 0, synchroniser 0; reset SHALL assert asynchronously and deassert synchronously.
REQ-029 A strobe edge during reset or within 2 clocks of deassertion SHALL NOT produce a tick.

Structure
REQ-030 Package multi_spinner_pkg SHALL hold the mode enum (WRAP, CLAMP, ANALOG, RECENTRE) and the direction typedef.
REQ-031 Sub-module spinner_channel SHALL implement one channel (step FSM plus value register); the top holds the synchroniser and a generate loop over CHANNELS.

Verification
REQ-032 WRAP, acc=0, STEP_FIXED=1, value 255, right held for 1 tick -> value 0, update pulses once.
REQ-033 acc=1, right held for 10 ticks from 128 -> steps 1,2,...,8,8,8 -> values 129,131,134,138,143,149,156,164,172,180.
REQ-034 CLAMP, value 250, right with step 8 -> 255 and held; left and right both pressed -> no change, next press uses step 1.
REQ-035 ANALOG, analog=-126 -> value 65; analog=0 with left -> digital clamp continues from 65.
REQ-036 RECENTRE from 131, no input -> 130, 129, 128, 128 over 4 ticks.
REQ-037 reset_n pulsed low mid-frame with an in-flight strobe edge -> all channels 128, no update pulse.
